// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle control sequencer for the lab datapath (regfile, A/B/C, shifter, ALU, status).
// Optional feature: define DATAPATH_SEQ_CMP_EN to make CMP (101/01) a legal instruction.
module datapath_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        done,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8
);

    localparam logic [2:0] WAIT      = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] GET_A     = 3'd2;
    localparam logic [2:0] GET_B     = 3'd3;
    localparam logic [2:0] EXEC      = 3'd4;
    localparam logic [2:0] WRITE     = 3'd5;
    localparam logic [2:0] WRITE_IMM = 3'd6;

`ifdef DATAPATH_SEQ_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    logic [2:0]  state, state_next;
    logic [15:0] ir;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, legal;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign legal      = is_mov_imm || is_mov_reg || (is_alu && (!is_cmp || CMP_EN));

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == WAIT && s)
                ir <= in;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            WAIT:      if (s) state_next = DECODE;
            DECODE: begin
                if (!legal)                     state_next = WAIT;
                else if (is_mov_imm)            state_next = WRITE_IMM;
                else if (is_mov_reg || is_mvn)  state_next = GET_B;
                else                            state_next = GET_A;
            end
            GET_A:     state_next = GET_B;
            GET_B:     state_next = EXEC;
            EXEC:      state_next = is_cmp ? WAIT : WRITE;
            WRITE:     state_next = WAIT;
            WRITE_IMM: state_next = WAIT;
            default:   state_next = WAIT;
        endcase
    end

    always_comb begin
        w        = (state == WAIT);
        done     = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state)
            DECODE: begin
                if (!legal) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            EXEC: begin
                shift = sh;
                // MOV reg passes B through as 0 + B; MVN ignores A entirely.
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else if (is_mvn) begin
                    asel  = 1'b1;
                    ALUop = 2'b11;
                end else begin
                    ALUop = op;
                end
                if (is_cmp) begin
`ifdef DATAPATH_SEQ_CMP_EN
                    loads = 1'b1;
`endif
                    done  = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            WRITE: begin
                vsel     = 1'b0;
                writenum = rd;
                write    = 1'b1;
                done     = 1'b1;
            end
            WRITE_IMM: begin
                vsel     = 1'b1;
                writenum = rn;
                write    = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: self-checking bench for datapath_seq; expected per-cycle control traces come
// from an instruction-level model that lists the strobes each instruction class should produce.
module tb_datapath_seq;

    typedef struct packed {
        logic        w;
        logic        done;
        logic        err;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic        vsel;
        logic [1:0]  shift;
        logic [1:0]  ALUop;
        logic [15:0] sximm8;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w, done, err, write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8;
    ctl_t        obs;

    int checks   = 0;
    int failures = 0;
    ctl_t        exp_q[$];
    logic [15:0] last_ir;

`ifdef DATAPATH_SEQ_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    datapath_seq dut (
        .clk(clk), .reset(reset), .s(s), .in(in),
        .w(w), .done(done), .err(err),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .ALUop(ALUop), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    assign obs = {w, done, err, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, ALUop, sximm8};

    function automatic ctl_t idle_of(input logic [15:0] ir);
        ctl_t c;
        c        = '0;
        c.w      = 1'b1;
        c.sximm8 = {{8{ir[7]}}, ir[7:0]};
        return c;
    endfunction

    // Lists, cycle by cycle after the accept edge, the control word each instruction should produce.
    task automatic build(input logic [15:0] ir);
        ctl_t base, c;
        bit mov_imm, mov_reg, alu, cmp, mvn, legal;
        mov_imm = (ir[15:11] == 5'b11010);
        mov_reg = (ir[15:11] == 5'b11000);
        alu     = (ir[15:13] == 3'b101);
        cmp     = (ir[15:11] == 5'b10101);
        mvn     = (ir[15:11] == 5'b10111);
        legal   = mov_imm || mov_reg || (alu && (!cmp || CMP_EN));
        base        = '0;
        base.sximm8 = {{8{ir[7]}}, ir[7:0]};
        exp_q.delete();
        c = base;
        if (!legal) begin
            c.done = 1'b1;
            c.err  = 1'b1;
        end
        exp_q.push_back(c);
        if (legal && mov_imm) begin
            c = base; c.vsel = 1'b1; c.writenum = ir[10:8]; c.write = 1'b1; c.done = 1'b1;
            exp_q.push_back(c);
        end else if (legal) begin
            if (!(mov_reg || mvn)) begin
                c = base; c.readnum = ir[10:8]; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = base; c.readnum = ir[2:0]; c.loadb = 1'b1;
            exp_q.push_back(c);
            c = base;
            c.shift = ir[4:3];
            c.asel  = mov_reg || mvn;
            c.ALUop = mov_reg ? 2'b00 : (mvn ? 2'b11 : ir[12:11]);
            if (cmp) begin
                c.loads = 1'b1;
                c.done  = 1'b1;
            end else begin
                c.loadc = 1'b1;
            end
            exp_q.push_back(c);
            if (!cmp) begin
                c = base; c.writenum = ir[7:5]; c.write = 1'b1; c.done = 1'b1;
                exp_q.push_back(c);
            end
        end
        exp_q.push_back(idle_of(ir));
    endtask

    // Starts at a negedge with the DUT in WAIT; ends at the negedge where it is back in WAIT.
    task automatic play(input string name, input logic [15:0] instr, input bit keep_s);
        build(instr);
        s  = 1'b1;
        in = instr;
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[i]) begin
                failures++;
                $display("FAIL %s instr=%h cycle=%0d got=%h exp=%h", name, instr, i + 1, obs, exp_q[i]);
            end
            if (i == 0) begin
                s  = keep_s;
                in = 16'($urandom);
            end
        end
        last_ir = instr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s     = 1'b0;
        in    = 16'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== idle_of(16'h0)) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, idle_of(16'h0));
        end
        reset   = 1'b0;
        last_ir = 16'h0;
    endtask

    task automatic test_idle();
        s  = 1'b0;
        in = 16'hD0FF;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (obs !== idle_of(last_ir)) begin
                failures++;
                $display("FAIL idle_no_start got=%h exp=%h", obs, idle_of(last_ir));
            end
        end
    endtask

    task automatic test_directed();
        play("mov_imm",  16'b110_10_001_11111110, 1'b0);
        play("add",      16'b101_00_000_010_00_001, 1'b0);
        play("cmp_lsl",  16'b101_01_011_000_01_100, 1'b0);
        play("mvn",      16'b101_11_000_101_00_110, 1'b0);
        play("mov_reg",  16'b110_00_000_111_10_010, 1'b0);
        play("illegal",  16'hE000, 1'b0);
        play("and",      16'b101_10_100_011_11_101, 1'b0);
    endtask

    task automatic test_back_to_back();
        play("b2b_first",  16'b110_10_010_00010111, 1'b1);
        play("b2b_second", 16'b110_10_110_10000001, 1'b1);
        play("b2b_third",  16'b101_00_001_100_10_011, 1'b0);
    endtask

    task automatic test_reset_mid();
        ctl_t z;
        s  = 1'b1;
        in = 16'b101_00_000_010_00_001;
        @(negedge clk);
        s = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!(loadb === 1'b1 && readnum === 3'd1)) begin
            failures++;
            $display("FAIL reset_mid_getb got loadb=%b readnum=%0d exp loadb=1 readnum=1", loadb, readnum);
        end
        reset = 1'b1;
        #1;
        z = idle_of(16'h0);
        checks++;
        if (obs !== z) begin
            failures++;
            $display("FAIL reset_mid_immediate got=%h exp=%h", obs, z);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (obs !== z) begin
                failures++;
                $display("FAIL reset_mid_abandon got=%h exp=%h", obs, z);
            end
        end
        last_ir = 16'h0;
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int n = 0; n < 60; n++) begin
            instr = 16'($urandom);
            case ($urandom_range(0, 3))
                0: instr[15:13] = 3'b110;
                1, 2: instr[15:13] = 3'b101;
                default: ;
            endcase
            play("random", instr, 1'($urandom_range(0, 1)));
        end
        play("random_tail", 16'b110_10_000_00000001, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_directed();
        test_idle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
